demultiplex: RTL and testbench



---
 rtl/demultiplex.sv | 82 ++++++++
 tb/tb_demultiplex.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demultiplex.sv
`default_nettype none
// ============================================================================
// Module  : demultiplex
// Purpose : Routes {index, data} words to N output channels, each backed by a
//           one-entry holding register; out-of-range words are dropped.
// Revision: 1.0
// ============================================================================
module demultiplex #(
  parameter  int W = 8,
  parameter  int N = 2,
  localparam int I = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_stb,
  input  logic [I+W-1:0] s_dat,
  output logic           s_rdy,
  output logic [N-1:0]   m_stb,
  output logic [N*W-1:0] m_dat,
  input  logic [N-1:0]   m_rdy,
  output logic           err
);

  localparam logic [I:0] c_N = (I+1)'(N);

  logic [I-1:0] w_idx;
  logic [W-1:0] w_data;
  logic         w_in_range;
  logic [N-1:0] w_sel;
  logic [N-1:0] w_free;
  logic         r_err;

  assign w_idx      = s_dat[I+W-1:W];
  assign w_data     = s_dat[W-1:0];
  assign w_in_range = ({1'b0, w_idx} < c_N);

  // Only the addressed channel's slot decides readiness; drops are always taken.
  assign s_rdy = ~w_in_range | (|(w_sel & w_free));
  assign err   = r_err;

  generate
    for (genvar k = 0; k < N; k++) begin : g_chan
      localparam logic [I-1:0] c_K = I'(k);

      logic         r_full;
      logic [W-1:0] r_data;
      logic         w_push;
      logic         w_pop;

      assign w_sel[k]  = w_in_range & (w_idx == c_K);
      assign w_free[k] = ~r_full | m_rdy[k];
      assign w_push    = s_stb & w_sel[k] & w_free[k];
      assign w_pop     = r_full & m_rdy[k];

      // A push in the same cycle as a pop reloads the slot without a bubble.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_full <= 1'b0;
          r_data <= '0;
        end else if (w_push) begin
          r_full <= 1'b1;
          r_data <= w_data;
        end else if (w_pop) begin
          r_full <= 1'b0;
        end
      end

      assign m_stb[k]         = r_full;
      assign m_dat[k*W +: W]  = r_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (s_stb & ~w_in_range) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demultiplex.sv
`default_nettype none
// ============================================================================
// Module  : tb_demultiplex
// Purpose : Directed bench for demultiplex with N=2 and N=3 instances.
// Revision: 1.0
// ============================================================================
module tb_demultiplex;

  logic        clk = 1'b0;
  logic        rst;

  logic        s_stb2;
  logic [8:0]  s_dat2;
  logic        s_rdy2;
  logic [1:0]  m_stb2;
  logic [15:0] m_dat2;
  logic [1:0]  m_rdy2;
  logic        err2;

  logic        s_stb3;
  logic [9:0]  s_dat3;
  logic        s_rdy3;
  logic [2:0]  m_stb3;
  logic [23:0] m_dat3;
  logic [2:0]  m_rdy3;
  logic        err3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demultiplex #(.W(8), .N(2)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .s_stb(s_stb2),
    .s_dat(s_dat2),
    .s_rdy(s_rdy2),
    .m_stb(m_stb2),
    .m_dat(m_dat2),
    .m_rdy(m_rdy2),
    .err  (err2)
  );

  demultiplex #(.W(8), .N(3)) u_dut3 (
    .clk  (clk),
    .rst  (rst),
    .s_stb(s_stb3),
    .s_dat(s_dat3),
    .s_rdy(s_rdy3),
    .m_stb(m_stb3),
    .m_dat(m_dat3),
    .m_rdy(m_rdy3),
    .err  (err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    s_stb2 = 1'b1;
    s_dat2 = {1'b1, 8'hAA};
    m_rdy2 = 2'b11;
    s_stb3 = 1'b0;
    s_dat3 = '0;
    m_rdy3 = 3'b111;

    // Reset held two cycles with a valid word presented
    tick;
    chk("rst1_mstb", 32'(m_stb2), 32'h0);
    chk("rst1_mdat", 32'(m_dat2), 32'h0);
    chk("rst1_err",  32'(err2),   32'h0);
    tick;
    chk("rst2_mstb", 32'(m_stb2), 32'h0);
    chk("rst2_mdat", 32'(m_dat2), 32'h0);
    chk("rst2_err3", 32'(err3),   32'h0);
    rst    = 1'b0;
    s_stb2 = 1'b0;
    #1;
    chk("post_rst_srdy", 32'(s_rdy2), 32'h1);
    tick;
    chk("post_rst_mstb", 32'(m_stb2), 32'h0);
    chk("post_rst_mdat", 32'(m_dat2), 32'h0);

    // Basic routing
    s_stb2 = 1'b1;
    s_dat2 = {1'b0, 8'h11};
    #1;
    chk("route0_srdy", 32'(s_rdy2), 32'h1);
    tick;
    chk("route0_mstb", 32'(m_stb2), 32'h1);
    chk("route0_dat",  32'(m_dat2[7:0]), 32'h11);
    s_dat2 = {1'b1, 8'h22};
    #1;
    chk("route1_srdy", 32'(s_rdy2), 32'h1);
    tick;
    chk("route1_mstb", 32'(m_stb2), 32'h2);
    chk("route1_dat",  32'(m_dat2[15:8]), 32'h22);
    s_stb2 = 1'b0;
    tick;
    chk("route_idle_mstb", 32'(m_stb2), 32'h0);

    // Back-pressure isolation: channel 0 stalled
    m_rdy2 = 2'b10;
    s_stb2 = 1'b1;
    s_dat2 = {1'b0, 8'h33};
    tick;
    chk("bp_33_mstb", 32'(m_stb2), 32'h1);
    chk("bp_33_dat",  32'(m_dat2[7:0]), 32'h33);
    s_dat2 = {1'b0, 8'h44};
    #1;
    chk("bp_44_blocked", 32'(s_rdy2), 32'h0);
    tick;
    chk("bp_33_held_mstb", 32'(m_stb2), 32'h1);
    chk("bp_33_held_dat",  32'(m_dat2[7:0]), 32'h33);
    chk("bp_44_still_blocked", 32'(s_rdy2), 32'h0);
    m_rdy2 = 2'b11;
    #1;
    chk("bp_44_ready", 32'(s_rdy2), 32'h1);
    tick;
    chk("bp_44_mstb", 32'(m_stb2), 32'h1);
    chk("bp_44_dat",  32'(m_dat2[7:0]), 32'h44);
    m_rdy2 = 2'b10;
    s_dat2 = {1'b1, 8'h55};
    #1;
    chk("bp_55_srdy", 32'(s_rdy2), 32'h1);
    tick;
    chk("bp_55_mstb", 32'(m_stb2), 32'h3);
    chk("bp_55_dat",  32'(m_dat2[15:8]), 32'h55);
    chk("bp_44_kept", 32'(m_dat2[7:0]),  32'h44);
    s_stb2 = 1'b0;
    m_rdy2 = 2'b11;
    tick;
    chk("bp_drain_mstb", 32'(m_stb2), 32'h0);

    // Full-rate pass-through on channel 0
    m_rdy2 = 2'b01;
    s_stb2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_dat2 = {1'b0, 8'(i)};
      #1;
      chk("fr_srdy", 32'(s_rdy2), 32'h1);
      tick;
      chk("fr_mstb0", 32'(m_stb2[0]), 32'h1);
      chk("fr_dat",   32'(m_dat2[7:0]), 32'(i));
    end
    s_stb2 = 1'b0;
    tick;
    chk("fr_end_mstb", 32'(m_stb2), 32'h0);

    // Out-of-range drop on the N=3 instance
    chk("oor_err_init", 32'(err3), 32'h0);
    s_stb3 = 1'b1;
    s_dat3 = {2'd3, 8'h77};
    #1;
    chk("oor_srdy", 32'(s_rdy3), 32'h1);
    tick;
    chk("oor_mstb", 32'(m_stb3), 32'h0);
    chk("oor_err",  32'(err3),   32'h1);
    s_dat3 = {2'd2, 8'h88};
    #1;
    chk("oor_next_srdy", 32'(s_rdy3), 32'h1);
    tick;
    chk("oor_next_mstb", 32'(m_stb3), 32'h4);
    chk("oor_next_dat",  32'(m_dat3[23:16]), 32'h88);
    chk("oor_err_sticky1", 32'(err3), 32'h1);
    s_stb3 = 1'b0;
    tick;
    chk("oor_err_sticky2", 32'(err3), 32'h1);
    chk("oor_idle_mstb", 32'(m_stb3), 32'h0);

    // Reset mid-operation with both channels full and stalled
    m_rdy2 = 2'b00;
    s_stb2 = 1'b1;
    s_dat2 = {1'b0, 8'hA1};
    tick;
    s_dat2 = {1'b1, 8'hB2};
    tick;
    s_stb2 = 1'b0;
    chk("mid_full_mstb", 32'(m_stb2), 32'h3);
    chk("mid_full_dat",  32'(m_dat2), 32'hB2A1);
    rst = 1'b1;
    tick;
    chk("mid_rst_mstb", 32'(m_stb2), 32'h0);
    chk("mid_rst_mdat", 32'(m_dat2), 32'h0);
    chk("mid_rst_err3", 32'(err3),   32'h0);
    rst    = 1'b0;
    m_rdy2 = 2'b11;
    tick;
    chk("mid_after1_mstb", 32'(m_stb2), 32'h0);
    tick;
    chk("mid_after2_mstb", 32'(m_stb2), 32'h0);
    chk("mid_after2_mdat", 32'(m_dat2), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
